// File: rtl/descrambler_ctrl.sv
// Sequences one 802.11 DATA field through an external descrambler and
// extracts the PSDU bits. Optional SERVICE check: DESC_CTRL_SERVICE_CHECK_EN.
module descrambler_ctrl #(
  parameter int LEN_W   = 12,
  parameter int NDBPS_W = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [LEN_W-1:0]   Length,
  input  logic [NDBPS_W-1:0] Ndbps,
  input  logic               In_Valid,
  input  logic               In_Data,
  output logic               Desc_En,
  output logic               Desc_Scrambled_Data,
  input  logic               Desc_Data,
  output logic               Out_Valid,
  output logic               Out_Data,
  output logic               Out_Last,
  output logic               Busy,
  output logic               Done,
  output logic               Err
);

  localparam int CNT_W = LEN_W + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVICE,
    S_PSDU,
    S_TAIL,
    S_PAD
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [NDBPS_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [NDBPS_W-1:0]   ndbps_q, ndbps_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
`ifdef DESC_CTRL_SERVICE_CHECK_EN
  logic                 svc_bad_q, svc_bad_d;
`endif

  logic [CNT_W-1:0]     psdu_bits;
  logic                 sym_wrap;
  logic [NDBPS_W-1:0]   sym_next;
  logic                 psdu_last;

  assign psdu_bits = {len_q, 3'b000};
  assign psdu_last = (bit_cnt_q == psdu_bits - 1'b1);
  // The symbol counter advances on every consumed bit of every phase.
  assign sym_wrap  = (sym_cnt_q == ndbps_q - 1'b1);
  assign sym_next  = sym_wrap ? '0 : sym_cnt_q + 1'b1;

  assign Busy                = (state_q != S_IDLE);
  assign Desc_En             = Busy & In_Valid;
  assign Desc_Scrambled_Data = In_Data;
  assign Out_Valid           = out_valid_q;
  assign Out_Data            = out_data_q;
  assign Out_Last            = out_last_q;
  assign Done                = done_q;
  assign Err                 = err_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    len_d       = len_q;
    ndbps_d     = ndbps_q;
    out_valid_d = 1'b0;
    out_data_d  = 1'b0;
    out_last_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef DESC_CTRL_SERVICE_CHECK_EN
    svc_bad_d   = svc_bad_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Length != '0 && Ndbps != '0) begin
            len_d     = Length;
            ndbps_d   = Ndbps;
            bit_cnt_d = '0;
            sym_cnt_d = '0;
            state_d   = S_SERVICE;
`ifdef DESC_CTRL_SERVICE_CHECK_EN
            svc_bad_d = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_SERVICE: begin
        if (In_Valid) begin
          sym_cnt_d = sym_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef DESC_CTRL_SERVICE_CHECK_EN
          if (bit_cnt_q >= CNT_W'(7) && Desc_Data) svc_bad_d = 1'b1;
`endif
          if (bit_cnt_q == CNT_W'(15)) begin
            bit_cnt_d = '0;
            state_d   = S_PSDU;
`ifdef DESC_CTRL_SERVICE_CHECK_EN
            if (svc_bad_q || Desc_Data) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
`endif
          end
        end else if (bit_cnt_q != '0) begin
          // Seed already in use: a gap cannot be recovered from.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_PSDU: begin
        if (In_Valid) begin
          sym_cnt_d   = sym_next;
          out_valid_d = 1'b1;
          out_data_d  = Desc_Data;
          out_last_d  = psdu_last;
          if (psdu_last) begin
            bit_cnt_d = '0;
            state_d   = S_TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_TAIL: begin
        if (In_Valid) begin
          sym_cnt_d = sym_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(5)) begin
            if (sym_wrap) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_PAD;
            end
          end
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_PAD: begin
        if (In_Valid) begin
          sym_cnt_d = sym_next;
          if (sym_wrap) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      len_q       <= '0;
      ndbps_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef DESC_CTRL_SERVICE_CHECK_EN
      svc_bad_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      len_q       <= len_d;
      ndbps_q     <= ndbps_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef DESC_CTRL_SERVICE_CHECK_EN
      svc_bad_q   <= svc_bad_d;
`endif
    end
  end

endmodule

// File: tb/tb_descrambler_ctrl.sv
// Self-checking bench for descrambler_ctrl: frame-level model of expected
// outputs plus a seed-recovering 802.11 descrambler stub.
module tb_descrambler_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [11:0] Length;
  logic [7:0]  Ndbps;
  logic        In_Valid;
  logic        In_Data;
  logic        Desc_En;
  logic        Desc_Scrambled_Data;
  logic        Desc_Data;
  logic        Out_Valid;
  logic        Out_Data;
  logic        Out_Last;
  logic        Busy;
  logic        Done;
  logic        Err;

  descrambler_ctrl #(.LEN_W(12), .NDBPS_W(8)) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .Start               (Start),
    .Length              (Length),
    .Ndbps               (Ndbps),
    .In_Valid            (In_Valid),
    .In_Data             (In_Data),
    .Desc_En             (Desc_En),
    .Desc_Scrambled_Data (Desc_Scrambled_Data),
    .Desc_Data           (Desc_Data),
    .Out_Valid           (Out_Valid),
    .Out_Data            (Out_Data),
    .Out_Last            (Out_Last),
    .Busy                (Busy),
    .Done                (Done),
    .Err                 (Err)
  );

  initial forever #5 Clk = ~Clk;

  // External descrambler: first 7 bits load the seed (SERVICE 0..6 are zero).
  logic [6:0] ds_s = 7'd0;
  int         ds_n = 0;
  always_comb Desc_Data = (ds_n < 7) ? 1'b0 : (Desc_Scrambled_Data ^ ds_s[3] ^ ds_s[6]);
  always @(posedge Clk) begin
    if (!Desc_En) begin
      ds_n <= 0;
    end else begin
      ds_s <= {ds_s[5:0], (ds_n < 7) ? Desc_Scrambled_Data : (ds_s[3] ^ ds_s[6])};
      if (ds_n < 100000) ds_n <= ds_n + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Expected outputs after the coming edge (x_*) and for the current cycle (ec_*).
  logic x_valid, x_data, x_last, x_done, x_err, x_busy;
  logic ec_valid, ec_data, ec_last, ec_done, ec_err, ec_busy;
  int cnt_valid, cnt_last, cnt_done, cnt_err;

  task automatic x_clear();
    x_valid = 0; x_data = 0; x_last = 0; x_done = 0; x_err = 0; x_busy = 0;
  endtask

  initial begin
    ec_valid = 0; ec_data = 0; ec_last = 0; ec_done = 0; ec_err = 0; ec_busy = 0;
    forever begin
      @(posedge Clk);
      ec_valid = x_valid; ec_data = x_data; ec_last = x_last;
      ec_done = x_done; ec_err = x_err; ec_busy = x_busy;
      @(negedge Clk);
      chk("busy", Busy, ec_busy);
      chk("out_valid", Out_Valid, ec_valid);
      chk("out_last", Out_Last, ec_last);
      chk("done", Done, ec_done);
      chk("err", Err, ec_err);
      chk("desc_en", Desc_En, ec_busy & In_Valid);
      chk("desc_scr", Desc_Scrambled_Data, In_Data);
      if (ec_valid) chk("out_data", Out_Data, ec_data);
      if (Out_Valid) cnt_valid++;
      if (Out_Last)  cnt_last++;
      if (Done)      cnt_done++;
      if (Err)       cnt_err++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int frame_bits(input int len, input int nd);
    int n;
    n = 22 + 8 * len;
    return ((n + nd - 1) / nd) * nd;
  endfunction

  bit dat[0:4095];
  bit scr[0:4095];
  bit pn [0:4095];

  task automatic clear_counts();
    cnt_valid = 0; cnt_last = 0; cnt_done = 0; cnt_err = 0;
  endtask

  task automatic run_frame(input int len, input int nd, input logic [6:0] seed,
                           input int gap, input int drop_at, input int start_mid_at,
                           input int reset_at, input bit svc_bad);
    int nbits;
    nbits = frame_bits(len, nd);
    for (int i = 0; i < nbits; i++) dat[i] = 1'b0;
    for (int i = 16; i < 16 + 8 * len; i++) dat[i] = 1'($urandom);
    if (svc_bad) dat[9] = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (i < 7) pn[i] = seed[6 - i];
      else       pn[i] = pn[i - 4] ^ pn[i - 7];
      scr[i] = dat[i] ^ pn[i];
    end
    clear_counts();

    Start = 1; Length = 12'(len); Ndbps = 8'(nd); In_Valid = 0;
    x_clear(); x_busy = 1;
    tick();
    Start = 0;
    for (int g = 0; g < gap; g++) begin
      x_clear(); x_busy = 1;
      tick();
    end

    for (int i = 0; i < nbits; i++) begin
      x_clear();
      Start = (i == start_mid_at);
      Length = (i == start_mid_at) ? 12'd3 : 12'(len);
      Ndbps  = (i == start_mid_at) ? 8'd24 : 8'(nd);
      if (i == drop_at) begin
        In_Valid = 0; x_err = 1;
        tick();
        break;
      end
      In_Valid = 1; In_Data = scr[i];
      if (i == reset_at) begin
        #1 Reset = 1;
        ec_valid = 0; ec_data = 0; ec_last = 0; ec_done = 0; ec_err = 0; ec_busy = 0;
        #1;
        chk("rst_desc_en", Desc_En, 1'b0);
        chk("rst_out_valid", Out_Valid, 1'b0);
        chk("rst_out_data", Out_Data, 1'b0);
        chk("rst_out_last", Out_Last, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_err", Err, 1'b0);
        tick();
        In_Valid = 0;
        Reset = 0;
        break;
      end
      x_valid = (i >= 16) && (i < 16 + 8 * len);
      x_data  = x_valid ? dat[i] : 1'b0;
      x_last  = (i == 16 + 8 * len - 1);
`ifdef DESC_CTRL_SERVICE_CHECK_EN
      if (svc_bad && i == 15) begin
        x_err = 1;
        tick();
        break;
      end
`endif
      x_done = (i == nbits - 1);
      x_busy = (i < nbits - 1);
      tick();
    end

    Start = 0; In_Valid = 0; Length = 12'(len); Ndbps = 8'(nd);
    x_clear();
    tick();
    tick();
    $display("frame len=%0d ndbps=%0d bits=%0d -> valid=%0d last=%0d done=%0d err=%0d",
             len, nd, nbits, cnt_valid, cnt_last, cnt_done, cnt_err);
  endtask

  task automatic bad_start(input int len, input int nd);
    clear_counts();
    Start = 1; Length = 12'(len); Ndbps = 8'(nd); In_Valid = 0;
    x_clear(); x_err = 1;
    tick();
    Start = 0;
    x_clear();
    tick();
    tick();
    chk("bad_start_err", cnt_err, 1);
    chk("bad_start_busy", Busy, 1'b0);
    $display("bad start len=%0d ndbps=%0d -> err=%0d", len, nd, cnt_err);
  endtask

  initial begin
    Reset = 1; Start = 0; Length = 0; Ndbps = 0; In_Valid = 0; In_Data = 0;
    x_clear();
    #2;
    chk("reset_busy", Busy, 1'b0);
    chk("reset_desc_en", Desc_En, 1'b0);
    chk("reset_out_valid", Out_Valid, 1'b0);
    chk("reset_done", Done, 1'b0);
    chk("reset_err", Err, 1'b0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 0;
    tick();

    // Model pins: frame length arithmetic.
    chk("bits_100_96", frame_bits(100, 96), 864);
    chk("pad_100_96", frame_bits(100, 96) - (22 + 800), 42);
    chk("bits_1_24", frame_bits(1, 24), 48);
    chk("bits_2_38", frame_bits(2, 38), 38);

    run_frame(100, 96, 7'b1011101, 3, -1, -1, -1, 1'b0);
    chk("f100_valid", cnt_valid, 800);
    chk("f100_last", cnt_last, 1);
    chk("f100_done", cnt_done, 1);
    chk("f100_err", cnt_err, 0);

    run_frame(1, 24, 7'b0110011, 0, -1, -1, -1, 1'b0);
    chk("f1_valid", cnt_valid, 8);
    chk("f1_done", cnt_done, 1);

    run_frame(2, 38, 7'b1111111, 1, -1, -1, -1, 1'b0);
    chk("f2_valid", cnt_valid, 16);
    chk("f2_done", cnt_done, 1);

    run_frame(20, 48, 7'b1000001, 0, 16 + 50, -1, -1, 1'b0);
    chk("drop_err", cnt_err, 1);
    chk("drop_done", cnt_done, 0);
    chk("drop_valid", cnt_valid, 50);
    chk("drop_busy", Busy, 1'b0);

    bad_start(0, 48);
    bad_start(5, 0);

    run_frame(10, 64, 7'b0101010, 2, -1, 16 + 30, -1, 1'b0);
    chk("mid_start_valid", cnt_valid, 80);
    chk("mid_start_done", cnt_done, 1);

    run_frame(4, 24, 7'b1100101, 0, -1, -1, -1, 1'b1);
`ifdef DESC_CTRL_SERVICE_CHECK_EN
    chk("svc_err", cnt_err, 1);
    chk("svc_valid", cnt_valid, 0);
    chk("svc_done", cnt_done, 0);
`else
    chk("svc_err", cnt_err, 0);
    chk("svc_valid", cnt_valid, 32);
    chk("svc_done", cnt_done, 1);
`endif

    run_frame(30, 72, 7'b0011100, 0, -1, -1, 16 + 40, 1'b0);
    chk("rst_mid_done", cnt_done, 0);
    chk("rst_mid_err", cnt_err, 0);
    run_frame(12, 48, 7'b1011101, 0, -1, -1, -1, 1'b0);
    chk("after_rst_valid", cnt_valid, 96);
    chk("after_rst_done", cnt_done, 1);

    for (int k = 0; k < 16; k++) begin
      int len, nd;
      logic [6:0] seed;
      len  = $urandom_range(1, 40);
      nd   = $urandom_range(24, 216);
      seed = 7'($urandom_range(1, 127));
      run_frame(len, nd, seed, $urandom_range(0, 3), -1, -1, -1, 1'b0);
      chk("rand_valid", cnt_valid, 8 * len);
      chk("rand_done", cnt_done, 1);
      chk("rand_err", cnt_err, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
